// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register: control-bundle
// field positions, default widths and occupancy encodings.
package pipe_pkg;

    localparam int unsigned MEM_READ   = 0;
    localparam int unsigned MEM_WRITE  = 1;
    localparam int unsigned MEM_TO_REG = 2;
    localparam int unsigned REG_WRITE  = 3;

    localparam int unsigned CTRL_W_DEF = 4;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    function automatic logic [1:0] occ_encode(input logic main_v, input logic skid_v);
        if (skid_v) return OCC_TWO;
        if (main_v) return OCC_ONE;
        return OCC_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One valid+payload holding register. Clear beats load; control is zeroed
// whenever the entry is (or becomes) invalid so bubbles never carry writes.
module pipe_entry_reg #(
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    input  logic [REG_W-1:0]  i_wreg,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [REG_W-1:0]  o_wreg
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [REG_W-1:0]  r_wreg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
            r_wreg  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
            r_wreg  <= i_wreg;
        end else if (!r_valid) begin
            r_ctrl  <= '0;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;
    assign o_wreg  = r_wreg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage latch with valid/ready handshake, optional
// 2-entry skid buffer, flush with bubble zeroing and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W   = CTRL_W_DEF,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_DATA = 2,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned SKID     = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [REG_W-1:0]           in_wreg,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [REG_W-1:0]           out_wreg,
    output logic [1:0]                 occupancy,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int unsigned PAY_W = NUM_DATA * DATA_W;

    logic              w_accept;
    logic              w_xfer;
    logic              w_main_v;
    logic              w_skid_v;
    logic              w_main_load;
    logic              w_main_clear;
    logic [CTRL_W-1:0] w_main_ctrl_in;
    logic [PAY_W-1:0]  w_main_data_in;
    logic [REG_W-1:0]  w_main_wreg_in;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_accept = in_valid & in_ready;
    assign w_xfer   = w_main_v & out_ready;

    pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (PAY_W),
        .REG_W  (REG_W)
    ) u_main (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_ctrl  (w_main_ctrl_in),
        .i_data  (w_main_data_in),
        .i_wreg  (w_main_wreg_in),
        .o_valid (w_main_v),
        .o_ctrl  (out_ctrl),
        .o_data  (out_data),
        .o_wreg  (out_wreg)
    );

    if (SKID == 1) begin : g_skid
        logic              w_skid_load;
        logic              w_skid_clear;
        logic              w_skid_next;
        logic [CTRL_W-1:0] w_skid_ctrl;
        logic [PAY_W-1:0]  w_skid_data;
        logic [REG_W-1:0]  w_skid_wreg;
        logic              r_in_ready;

        // Main refills from skid when skid holds the older entry, otherwise from the input.
        assign w_main_load  = ~flush & ((~w_main_v & w_accept) |
                                        (w_main_v & w_xfer & (w_skid_v | w_accept)));
        assign w_main_clear = flush | (w_main_v & w_xfer & ~w_skid_v & ~w_accept);
        assign w_skid_load  = ~flush & w_main_v & ~w_skid_v & w_accept & ~w_xfer;
        assign w_skid_clear = flush | (w_skid_v & w_xfer);
        assign w_skid_next  = ~flush & (w_skid_load | (w_skid_v & ~w_xfer));

        assign w_main_ctrl_in = w_skid_v ? w_skid_ctrl : in_ctrl;
        assign w_main_data_in = w_skid_v ? w_skid_data : in_data;
        assign w_main_wreg_in = w_skid_v ? w_skid_wreg : in_wreg;

        pipe_entry_reg #(
            .CTRL_W (CTRL_W),
            .DATA_W (PAY_W),
            .REG_W  (REG_W)
        ) u_skid (
            .i_clk   (clk),
            .i_rst_n (rst),
            .i_load  (w_skid_load),
            .i_clear (w_skid_clear),
            .i_ctrl  (in_ctrl),
            .i_data  (in_data),
            .i_wreg  (in_wreg),
            .o_valid (w_skid_v),
            .o_ctrl  (w_skid_ctrl),
            .o_data  (w_skid_data),
            .o_wreg  (w_skid_wreg)
        );

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) r_in_ready <= 1'b0;
            else      r_in_ready <= ~w_skid_next;
        end

        assign in_ready = r_in_ready;
    end else begin : g_noskid
        assign w_skid_v       = 1'b0;
        assign w_main_load    = ~flush & w_accept;
        assign w_main_clear   = flush | (w_xfer & ~w_accept);
        assign w_main_ctrl_in = in_ctrl;
        assign w_main_data_in = in_data;
        assign w_main_wreg_in = in_wreg;
        assign in_ready       = ~w_main_v | out_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_main_v && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid = w_main_v;
    assign occupancy = occ_encode(w_main_v, w_skid_v);
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg: three instances (skid,
// no-skid, skid with 3-bit counter) checked against a FIFO-level model.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [63:0] data;
        logic [4:0]  wreg;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_ctrl = '0;
    logic [63:0] in_data = '0;
    logic [4:0]  in_wreg = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        v0, v1, v2, r0, r1, r2;
    logic [3:0]  c0, c1, c2;
    logic [63:0] d0, d1, d2;
    logic [4:0]  w0, w1, w2;
    logic [1:0]  o0, o1, o2;
    logic [15:0] s0, s1;
    logic [2:0]  s2;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .NUM_DATA(2), .REG_W(5), .SKID(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .in_ctrl(in_ctrl),
        .in_data(in_data), .in_wreg(in_wreg), .flush(flush), .out_valid(v0),
        .out_ready(out_ready), .out_ctrl(c0), .out_data(d0), .out_wreg(w0),
        .occupancy(o0), .stall_cnt(s0));

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .NUM_DATA(2), .REG_W(5), .SKID(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1), .in_ctrl(in_ctrl),
        .in_data(in_data), .in_wreg(in_wreg), .flush(flush), .out_valid(v1),
        .out_ready(out_ready), .out_ctrl(c1), .out_data(d1), .out_wreg(w1),
        .occupancy(o1), .stall_cnt(s1));

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .NUM_DATA(2), .REG_W(5), .SKID(1), .CNT_W(3)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2), .in_ctrl(in_ctrl),
        .in_data(in_data), .in_wreg(in_wreg), .flush(flush), .out_valid(v2),
        .out_ready(out_ready), .out_ctrl(c2), .out_data(d2), .out_wreg(w2),
        .occupancy(o2), .stall_cnt(s2));

    // Model: per instance a small FIFO (head at index 0), a ready flag and a stall count.
    ent_t        m_e   [3][2];
    int unsigned m_n   [3];
    logic        m_rdy [3];
    int unsigned m_st  [3];
    int unsigned m_max [3] = '{65535, 65535, 7};

    function automatic logic exp_rdy(input int unsigned i);
        if (i == 1) return (m_n[i] == 0) || out_ready;
        return m_rdy[i];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_n[i] = 0; m_rdy[i] = 1'b0; m_st[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic acc, xf;
                acc = in_valid && exp_rdy(i);
                xf  = (m_n[i] > 0) && out_ready;
                if ((m_n[i] > 0) && !out_ready && (m_st[i] < m_max[i])) m_st[i]++;
                if (flush) begin
                    m_n[i] = 0;
                end else begin
                    if (xf) begin m_e[i][0] = m_e[i][1]; m_n[i]--; end
                    if (acc) begin m_e[i][m_n[i]] = {in_ctrl, in_data, in_wreg}; m_n[i]++; end
                end
                m_rdy[i] = (m_n[i] < 2);
            end
        end
    end

    task automatic cmp(input string nm, input int unsigned i, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h exp %h at %0t", nm, i, got, exp, $time);
        end
    endtask

    task automatic chk(input int unsigned i, input logic v, input logic rdy, input logic [3:0] c,
                       input logic [63:0] d, input logic [4:0] w, input logic [1:0] occ,
                       input logic [15:0] st);
        logic ev;
        ev = m_n[i] > 0;
        cmp("out_valid", i, 64'(v), 64'(ev));
        cmp("in_ready", i, 64'(rdy), 64'(exp_rdy(i)));
        cmp("occupancy", i, 64'(occ), 64'(m_n[i]));
        cmp("stall_cnt", i, 64'(st), 64'(m_st[i]));
        cmp("out_ctrl", i, 64'(c), ev ? 64'(m_e[i][0].ctrl) : 64'd0);
        if (ev) begin
            cmp("out_data", i, d, m_e[i][0].data);
            cmp("out_wreg", i, 64'(w), 64'(m_e[i][0].wreg));
        end
    endtask

    always @(negedge clk) begin
        chk(0, v0, r0, c0, d0, w0, o0, s0);
        chk(1, v1, r1, c1, d1, w1, o1, s1);
        chk(2, v2, r2, c2, d2, w2, o2, {13'd0, s2});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input ent_t e);
        in_valid = 1'b1;
        in_ctrl  = e.ctrl;
        in_data  = e.data;
        in_wreg  = e.wreg;
    endtask

    function automatic ent_t mk(input logic [3:0] c, input logic [31:0] w1v, input logic [31:0] w0v,
                                input logic [4:0] r);
        ent_t e;
        e.ctrl = c; e.data = {w1v, w0v}; e.wreg = r;
        return e;
    endfunction

    ent_t stream [4];
    ent_t ex, ey, ez;

    initial begin
        stream[0] = mk(4'b1001, 32'h0000_000A, 32'h0000_0011, 5'd1);
        stream[1] = mk(4'b0010, 32'h0000_000B, 32'h0000_0022, 5'd2);
        stream[2] = mk(4'b1100, 32'h0000_000C, 32'h0000_0033, 5'd3);
        stream[3] = mk(4'b1000, 32'h0000_000D, 32'h0000_0044, 5'd4);
        ex = mk(4'b1000, 32'h1111_1111, 32'hAAAA_0001, 5'd10);
        ey = mk(4'b0010, 32'h2222_2222, 32'hBBBB_0002, 5'd11);
        ez = mk(4'b1001, 32'h3333_3333, 32'hCCCC_0003, 5'd12);

        // Reset with a live-looking input held at the ports.
        #1 rst = 1'b0;
        in_valid = 1'b1; in_ctrl = 4'b1111; in_data = 64'hDEAD_BEEF_CAFE_F00D; in_wreg = 5'd31;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst_valid", 0, 64'(v0), 64'd0);
        cmp("rst_ctrl", 0, 64'(c0), 64'd0);
        cmp("rst_occ", 0, 64'(o0), 64'd0);
        cmp("rst_stall", 0, 64'(s0), 64'd0);
        cmp("rst_rdy_skid", 0, 64'(r0), 64'd0);
        cmp("rst_rdy_noskid", 1, 64'(r1), 64'd1);
        step();
        rst = 1'b1; in_valid = 1'b0; in_ctrl = '0;
        step();
        @(negedge clk);
        cmp("post_rst_valid", 0, 64'(v0), 64'd0);
        cmp("post_rst_rdy", 0, 64'(r0), 64'd1);

        // Streaming with out_ready held high.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            drive(stream[k]);
            if (k > 0) begin
                @(negedge clk);
                cmp("stream_data", 0, d0, stream[k-1].data);
                cmp("stream_occ", 0, 64'(o0), 64'd1);
                cmp("stream_rdy", 0, 64'(r0), 64'd1);
            end
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        cmp("stream_last", 0, d0, 64'h0000_000D_0000_0044);
        step(); step();

        // Backpressure into the skid buffer.
        out_ready = 1'b0;
        drive(ex); step();
        drive(ey); step();
        drive(ez);
        @(negedge clk);
        cmp("bp_occ", 0, 64'(o0), 64'd2);
        cmp("bp_rdy", 0, 64'(r0), 64'd0);
        cmp("bp_data", 0, d0, ex.data);
        cmp("bp_stall1", 0, 64'(s0), 64'd1);
        step();
        @(negedge clk);
        cmp("bp_stall2", 0, 64'(s0), 64'd2);
        cmp("bp_hold", 0, d0, ex.data);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        cmp("bp_second", 0, d0, ey.data);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        cmp("bp_third", 0, d0, ez.data);
        step(); step();

        // Flush with two held entries and a simultaneous input.
        out_ready = 1'b0;
        drive(ex); step();
        drive(ey); step();
        flush = 1'b1; drive(ez); step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        cmp("fl_valid", 0, 64'(v0), 64'd0);
        cmp("fl_ctrl", 0, 64'(c0), 64'd0);
        cmp("fl_occ", 0, 64'(o0), 64'd0);
        cmp("fl_rdy", 0, 64'(r0), 64'd1);
        out_ready = 1'b1;
        step(); step();

        // No-skid instance: in_ready follows out_ready combinationally.
        out_ready = 1'b0;
        drive(ex); step();
        drive(ey);
        @(negedge clk);
        cmp("ns_rdy_lo", 1, 64'(r1), 64'd0);
        step();
        out_ready = 1'b1;
        #1;
        cmp("ns_rdy_hi", 1, 64'(r1), 64'd1);
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        #1;
        cmp("ns_rdy_lo2", 1, 64'(r1), 64'd0);
        out_ready = 1'b1;
        step(); step(); step();

        // Saturation of the 3-bit counter.
        out_ready = 1'b0;
        drive(ez); step();
        in_valid = 1'b0;
        repeat (10) step();
        @(negedge clk);
        cmp("sat_stall", 2, 64'(s2), 64'd7);
        out_ready = 1'b1;
        step(); step(); step();

        // Random traffic with one asynchronous reset in the middle.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            step();
            rst       = (cyc != 1000);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 31) == 0);
            in_ctrl   = 4'($urandom);
            in_data   = {$urandom, $urandom};
            in_wreg   = 5'($urandom);
        end
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
